// File: rtl/tl_pkg.sv
// tl_pkg -- shared definitions for the traffic-light scheduler.
//   phase_t     : 3-bit phase code driven to the lamp decoder
//   PH_*        : phase encodings (START, NS, NY, EW, EY, AR)
//   DIR_*       : emergency direction codes on i_emg_dir
//   green_of()  : maps a direction to its green phase code
package tl_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_START = 3'b111;
  localparam phase_t PH_NS    = 3'b011;
  localparam phase_t PH_NY    = 3'b010;
  localparam phase_t PH_EW    = 3'b000;
  localparam phase_t PH_EY    = 3'b001;
  localparam phase_t PH_AR    = 3'b100;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  function automatic phase_t green_of(input logic dir);
    return (dir == DIR_EW) ? PH_EW : PH_NS;
  endfunction

endpackage

// File: rtl/tl_dncnt.sv
// tl_dncnt -- loadable down-counter used as the phase timer.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-high reset, loads RST_VAL
//   i_load     : load i_load_val (has priority over hold)
//   i_hold     : keep the current value
//   i_load_val : value to load
//   o_cnt      : current count
//   o_zero     : count equals zero
module tl_dncnt #(
  parameter int                 T_WIDTH = 8,
  parameter logic [T_WIDTH-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_hold,
  input  logic [T_WIDTH-1:0] i_load_val,
  output logic [T_WIDTH-1:0] o_cnt,
  output logic               o_zero
);

  logic [T_WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tl_sched.sv
// tl_sched -- traffic-light phase scheduler with pedestrian walk service and
// emergency preemption.
//   i_clk, i_rst        : clock (rising edge), async active-high reset
//   i_ped_ns / i_ped_ew : pedestrian calls, latched until served
//   i_emg_req/i_emg_dir : emergency request (level) and direction (0=NS,1=EW)
//   o_state             : current phase code (see tl_pkg)
//   o_walk_ns/o_walk_ew : walk lamps, held for the whole served green
//   o_emg_ack           : requested green is active (combinational)
//   o_remain            : phase timer, cycles left minus one
module tl_sched
  import tl_pkg::*;
#(
  parameter int T_WIDTH = 8,
  parameter int NS_TIME = 8,
  parameter int EW_TIME = 6,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2,
  parameter int PED_EXT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ped_ns,
  input  logic               i_ped_ew,
  input  logic               i_emg_req,
  input  logic               i_emg_dir,
  output logic [2:0]         o_state,
  output logic               o_walk_ns,
  output logic               o_walk_ew,
  output logic               o_emg_ack,
  output logic [T_WIDTH-1:0] o_remain
);

  if (NS_TIME + PED_EXT > (1 << T_WIDTH)) begin : g_ns_width_bad
    $error("tl_sched: NS_TIME+PED_EXT does not fit in T_WIDTH");
  end
  if (EW_TIME + PED_EXT > (1 << T_WIDTH)) begin : g_ew_width_bad
    $error("tl_sched: EW_TIME+PED_EXT does not fit in T_WIDTH");
  end

  // Timer load values are duration-1 so a phase lasts exactly `duration`.
  localparam logic [T_WIDTH-1:0] NS_LD  = T_WIDTH'(NS_TIME - 1);
  localparam logic [T_WIDTH-1:0] NSP_LD = T_WIDTH'(NS_TIME + PED_EXT - 1);
  localparam logic [T_WIDTH-1:0] EW_LD  = T_WIDTH'(EW_TIME - 1);
  localparam logic [T_WIDTH-1:0] EWP_LD = T_WIDTH'(EW_TIME + PED_EXT - 1);
  localparam logic [T_WIDTH-1:0] Y_LD   = T_WIDTH'(Y_TIME - 1);
  localparam logic [T_WIDTH-1:0] AR_LD  = T_WIDTH'(AR_TIME - 1);

  phase_t             r_state;
  logic               r_walk_ns, r_walk_ew;
  logic               r_lat_ns, r_lat_ew;
  logic               r_pre;      // preemption in progress toward r_pre_dir
  logic               r_pre_dir;

  phase_t             w_next_state;
  logic               w_walk_ns_n, w_walk_ew_n, w_lat_ns_n, w_lat_ew_n;
  logic               w_pre_n, w_pre_dir_n;
  logic               w_load, w_hold, w_zero;
  logic               w_go_ns, w_go_ew;
  logic               w_green_dir;
  logic [T_WIDTH-1:0] w_load_val, w_remain, w_green_base;

  tl_dncnt #(
    .T_WIDTH (T_WIDTH),
    .RST_VAL (Y_LD)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_hold     (w_hold),
    .i_load_val (w_load_val),
    .o_cnt      (w_remain),
    .o_zero     (w_zero)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_hold       = 1'b0;
    w_load_val   = '0;
    w_go_ns      = 1'b0;
    w_go_ew      = 1'b0;
    w_walk_ns_n  = r_walk_ns;
    w_walk_ew_n  = r_walk_ew;
    w_lat_ns_n   = r_lat_ns | i_ped_ns;
    w_lat_ew_n   = r_lat_ew | i_ped_ew;
    // A live request (re)arms preemption; the latched copy lets the sequence
    // finish into the requested green even if the request drops.
    w_pre_n      = r_pre | i_emg_req;
    w_pre_dir_n  = i_emg_req ? i_emg_dir : r_pre_dir;
    w_green_dir  = (r_state == PH_EW) ? DIR_EW : DIR_NS;
    w_green_base = (r_state == PH_EW) ? EW_LD : NS_LD;

    case (r_state)
      PH_START: begin
        if (w_zero) begin
          if (w_pre_n) begin
            w_next_state = green_of(w_pre_dir_n);
            w_load       = 1'b1;
            w_load_val   = (w_pre_dir_n == DIR_EW) ? EW_LD : NS_LD;
            w_pre_n      = 1'b0;
          end else begin
            w_go_ns = 1'b1;
          end
        end
      end
      PH_NS, PH_EW: begin
        if (i_emg_req && (i_emg_dir == w_green_dir)) begin
          // Held green: timer sits at its load value, walk suppressed.
          w_pre_n     = 1'b0;
          w_walk_ns_n = 1'b0;
          w_walk_ew_n = 1'b0;
          if (w_remain == w_green_base) begin
            w_hold = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_load_val = w_green_base;
          end
        end else if (i_emg_req || w_zero) begin
          w_next_state = (r_state == PH_NS) ? PH_NY : PH_EY;
          w_load       = 1'b1;
          w_load_val   = Y_LD;
          w_walk_ns_n  = 1'b0;
          w_walk_ew_n  = 1'b0;
        end
      end
      PH_NY, PH_EY: begin
        if (w_zero) begin
          if (w_pre_n) begin
            w_next_state = PH_AR;
            w_load       = 1'b1;
            w_load_val   = AR_LD;
          end else if (r_state == PH_NY) begin
            w_go_ew = 1'b1;
          end else begin
            w_go_ns = 1'b1;
          end
        end
      end
      PH_AR: begin
        // Green entered via all-red never grants walk; latches persist.
        if (w_zero) begin
          w_next_state = green_of(w_pre_dir_n);
          w_load       = 1'b1;
          w_load_val   = (w_pre_dir_n == DIR_EW) ? EW_LD : NS_LD;
          w_pre_n      = 1'b0;
        end
      end
      default: begin
        w_next_state = PH_START;
        w_load       = 1'b1;
        w_load_val   = Y_LD;
        w_pre_n      = 1'b0;
      end
    endcase

    // Normal green entry: serve a latched or same-cycle call with extension.
    if (w_go_ns) begin
      w_next_state = PH_NS;
      w_load       = 1'b1;
      if (r_lat_ns | i_ped_ns) begin
        w_walk_ns_n = 1'b1;
        w_lat_ns_n  = 1'b0;
        w_load_val  = NSP_LD;
      end else begin
        w_load_val  = NS_LD;
      end
    end
    if (w_go_ew) begin
      w_next_state = PH_EW;
      w_load       = 1'b1;
      if (r_lat_ew | i_ped_ew) begin
        w_walk_ew_n = 1'b1;
        w_lat_ew_n  = 1'b0;
        w_load_val  = EWP_LD;
      end else begin
        w_load_val  = EW_LD;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= PH_START;
      r_walk_ns <= 1'b0;
      r_walk_ew <= 1'b0;
      r_lat_ns  <= 1'b0;
      r_lat_ew  <= 1'b0;
      r_pre     <= 1'b0;
      r_pre_dir <= DIR_NS;
    end else begin
      r_state   <= w_next_state;
      r_walk_ns <= w_walk_ns_n;
      r_walk_ew <= w_walk_ew_n;
      r_lat_ns  <= w_lat_ns_n;
      r_lat_ew  <= w_lat_ew_n;
      r_pre     <= w_pre_n;
      r_pre_dir <= w_pre_dir_n;
    end
  end

  assign o_state   = r_state;
  assign o_walk_ns = r_walk_ns;
  assign o_walk_ew = r_walk_ew;
  assign o_remain  = w_remain;
  assign o_emg_ack = i_emg_req & (r_state == green_of(i_emg_dir));

endmodule
